// File: rtl/window_motor_drive.sv
// H-bridge driver for the window motor: runs toward a limit switch, enforces a run
// time budget, and inserts a both-legs-off dead time before any new run.
module window_motor_drive #(
  parameter int CNT_W       = 24,
  parameter int RUN_TIMEOUT = 5000000,
  parameter int DEAD_TIME   = 1000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       open_cw,
  input  logic       close_ccw,
  input  logic       limit_open,
  input  logic       limit_closed,
  output logic       motor_cw,
  output logic       motor_ccw,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN_CW  = 3'd1,
    S_RUN_CCW = 3'd2,
    S_DEAD    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_NONE  = 2'd0,
    C_OPEN  = 2'd1,
    C_CLOSE = 2'd2
  } cmd_t;

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             pend_q, pend_d;
  cmd_t             cmd;

  // Simultaneous open and close requests are contradictory and treated as no command.
  always_comb begin
    cmd = C_NONE;
    if (open_cw && !close_ccw)      cmd = C_OPEN;
    else if (close_ccw && !open_cw) cmd = C_CLOSE;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= C_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (state_q != S_FAULT && limit_open && limit_closed) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd == C_OPEN && !limit_open) begin
            state_d = S_RUN_CW;
            cnt_d   = '0;
          end else if (cmd == C_CLOSE && !limit_closed) begin
            state_d = S_RUN_CCW;
            cnt_d   = '0;
          end
        end
        S_RUN_CW: begin
          if (limit_open) begin
            state_d = S_DEAD;
            cnt_d   = '0;
            pend_d  = C_NONE;
          end else if (cnt_q == RUN_LAST) begin
            state_d = S_FAULT;
          end else if (cmd == C_CLOSE) begin
            state_d = S_DEAD;
            cnt_d   = '0;
            pend_d  = C_CLOSE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN_CCW: begin
          if (limit_closed) begin
            state_d = S_DEAD;
            cnt_d   = '0;
            pend_d  = C_NONE;
          end else if (cnt_q == RUN_LAST) begin
            state_d = S_FAULT;
          end else if (cmd == C_OPEN) begin
            state_d = S_DEAD;
            cnt_d   = '0;
            pend_d  = C_OPEN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DEAD: begin
          // A command seen on the final dead cycle still counts as the latest request.
          if (cmd != C_NONE) pend_d = cmd;
          if (cnt_q == DEAD_LAST) begin
            if (pend_d == C_OPEN && !limit_open)         state_d = S_RUN_CW;
            else if (pend_d == C_CLOSE && !limit_closed) state_d = S_RUN_CCW;
            else                                         state_d = S_IDLE;
            cnt_d  = '0;
            pend_d = C_NONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_FAULT;
      endcase
    end
  end

  always_comb begin
    motor_cw  = (state_q == S_RUN_CW);
    motor_ccw = (state_q == S_RUN_CCW);
    busy      = (state_q == S_RUN_CW) || (state_q == S_RUN_CCW) || (state_q == S_DEAD);
    fault     = (state_q == S_FAULT);
    state_o   = state_q;
  end

endmodule

// File: tb/tb_window_motor_drive.sv
// Directed and randomized bench for window_motor_drive, scored against a run/dead-time
// model expressed as direction, elapsed run time and remaining dead time.
module tb_window_motor_drive;

  localparam int CNT_W = 8;
  localparam int RT    = 20;
  localparam int DT    = 4;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       open_cw = 1'b0, close_ccw = 1'b0;
  logic       limit_open = 1'b0, limit_closed = 1'b0;
  logic       motor_cw, motor_ccw, busy, fault;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;

  // model: dir +1 opening, -1 closing, 0 stopped; dead_left > 0 while legs are forced off
  int  m_dir = 0, m_used = 0, m_dead_left = 0, m_pend = 0;
  bit  m_fault = 1'b0;

  window_motor_drive #(.CNT_W(CNT_W), .RUN_TIMEOUT(RT), .DEAD_TIME(DT)) dut (
    .clk(clk), .n_reset(n_reset), .open_cw(open_cw), .close_ccw(close_ccw),
    .limit_open(limit_open), .limit_closed(limit_closed),
    .motor_cw(motor_cw), .motor_ccw(motor_ccw), .busy(busy), .fault(fault),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int req();
    if (open_cw && !close_ccw) return 1;
    if (close_ccw && !open_cw) return -1;
    return 0;
  endfunction

  function automatic bit at_limit(input int d);
    return (d == 1) ? limit_open : limit_closed;
  endfunction

  task automatic try_start(input int d);
    if (d != 0 && !at_limit(d)) begin
      m_dir  = d;
      m_used = 0;
    end
  endtask

  task automatic model_edge();
    int c;
    c = req();
    if (!n_reset) begin
      m_dir = 0; m_used = 0; m_dead_left = 0; m_pend = 0; m_fault = 1'b0;
    end else if (m_fault) begin
      // stuck until reset
    end else if (limit_open && limit_closed) begin
      m_fault = 1'b1; m_dir = 0; m_dead_left = 0;
    end else if (m_dir != 0) begin
      if (at_limit(m_dir)) begin
        m_dir = 0; m_dead_left = DT; m_pend = 0;
      end else if (m_used == RT - 1) begin
        m_dir = 0; m_fault = 1'b1;
      end else if (c == -m_dir) begin
        m_dir = 0; m_dead_left = DT; m_pend = c;
      end else begin
        m_used++;
      end
    end else if (m_dead_left > 0) begin
      if (c != 0) m_pend = c;
      if (m_dead_left == 1) begin
        m_dead_left = 0;
        try_start(m_pend);
        m_pend = 0;
      end else begin
        m_dead_left--;
      end
    end else begin
      try_start(c);
    end
  endtask

  // One clock: inputs already applied, model advances on the edge, outputs compared 1 time unit later.
  task automatic cyc(input bit op, input bit cl, input bit lo, input bit lc, input bit rst_n);
    open_cw = op; close_ccw = cl; limit_open = lo; limit_closed = lc; n_reset = rst_n;
    @(posedge clk);
    model_edge();
    #1;
    check("motor_cw",  int'(motor_cw),  int'(m_dir == 1));
    check("motor_ccw", int'(motor_ccw), int'(m_dir == -1));
    check("busy",      int'(busy),      int'(m_dir != 0 || m_dead_left > 0));
    check("fault",     int'(fault),     int'(m_fault));
    check("exclusive", int'(motor_cw & motor_ccw), 0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
  endtask

  int cw_cnt, gap;

  initial begin
    @(negedge clk);
    // reset then idle
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    idle(10);

    // normal open ending on the open limit
    cyc(1, 0, 0, 0, 1);
    idle(6);
    cyc(0, 0, 1, 0, 1);
    idle(8);

    // timeout: motor on for exactly RT cycles, then latched fault
    cw_cnt = 0;
    cyc(1, 0, 0, 0, 1);
    if (motor_cw) cw_cnt++;
    for (int i = 0; i < 25; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (motor_cw) cw_cnt++;
    end
    check("timeout_len", cw_cnt, RT);
    check("timeout_fault", int'(fault), 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);
    check("fault_cleared", int'(fault), 0);
    idle(2);

    // reversal: both legs off for DT cycles, then closing
    cyc(1, 0, 0, 0, 1);
    idle(5);
    gap = 0;
    cyc(0, 1, 0, 0, 1);
    if (!motor_ccw) gap++;
    for (int i = 0; i < 10 && !motor_ccw; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (!motor_ccw) gap++;
    end
    check("dead_gap", gap, DT);
    check("reversed", int'(motor_ccw), 1);
    idle(4);
    cyc(0, 0, 0, 1, 1);
    idle(DT + 2);

    // ignored commands
    cyc(1, 0, 1, 0, 1);
    check("open_at_limit", int'(busy), 0);
    cyc(1, 1, 0, 0, 1);
    check("both_cmds", int'(busy), 0);
    cw_cnt = 0;
    cyc(1, 0, 0, 0, 1);
    if (motor_cw) cw_cnt++;
    for (int i = 0; i < 24; i++) begin
      cyc((i % 5) == 2, 0, 0, 0, 1);
      if (motor_cw) cw_cnt++;
    end
    check("no_restart", cw_cnt, RT);
    cyc(0, 0, 0, 0, 0);
    idle(2);

    // both limits during a close run, then a reset mid-open
    cyc(0, 1, 0, 0, 1);
    idle(3);
    cyc(0, 0, 1, 1, 1);
    check("sensor_fault", int'(fault), 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    idle(3);
    cyc(0, 0, 0, 0, 0);
    check("reset_midrun", int'({motor_cw, motor_ccw, busy, fault}), 0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 299) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/window_motor_drive.md
Name: window_motor_drive

Overview:
- Downstream stage of the window open/close FSM. Consumes its `open_cw` / `close_ccw` command pulses and drives the two H-bridge enables for the window motor.
- Each run stops on the end-of-travel limit switch.
- A run that exceeds its time budget is treated as a fault.
- Both bridge legs are forced off for a dead-time before any direction reversal, so `motor_cw` and `motor_ccw` are never asserted together.

Parameters:
- CNT_W, 24, width of the shared run/dead-time counter.
- RUN_TIMEOUT, 5000000, maximum cycles a single run may drive the motor; must be >= 2 and < 2^CNT_W.
- DEAD_TIME, 1000, cycles with both legs off between runs; must be >= 1 and < 2^CNT_W.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- n_reset, input, 1, synchronous active-low reset.
- open_cw, input, 1, open command from the window FSM (level sampled each cycle).
- close_ccw, input, 1, close command from the window FSM.
- limit_open, input, 1, high when the window is fully open (already synchronised).
- limit_closed, input, 1, high when the window is fully closed (already synchronised).
- motor_cw, output, 1, bridge enable, opening direction.
- motor_ccw, output, 1, bridge enable, closing direction.
- busy, output, 1, high in RUN_CW, RUN_CCW and DEAD.
- fault, output, 1, high in FAULT.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is `clk`; reset port is `n_reset`.
- Reset: `n_reset` == 0 at an edge sets state = IDLE, counter = 0, pending = NONE, and all outputs to 0. Reset has priority over everything, including mid-run and FAULT.
- Outputs are Moore, decoded from registered state:
  - motor_cw = (state == RUN_CW)
  - motor_ccw = (state == RUN_CCW)
  - busy = RUN_CW | RUN_CCW | DEAD
  - fault = (state == FAULT)
- Command decode each cycle:
  - cmd = OPEN if open_cw & ~close_ccw.
  - cmd = CLOSE if close_ccw & ~open_cw.
  - Otherwise cmd = NONE; both high together is ignored.
- Global rule: limit_open & limit_closed both high in any non-FAULT state goes to FAULT at the next edge.
- IDLE:
  - OPEN & ~limit_open: go to RUN_CW, counter = 0.
  - CLOSE & ~limit_closed: go to RUN_CCW, counter = 0.
  - Command toward an already-asserted limit: stay in IDLE.
  - Latency: the command is sampled at edge k; the motor output is high from edge k+1.
- RUN_CW. Priority order per cycle:
  1. limit_open: go to DEAD, pending = NONE.
  2. counter == RUN_TIMEOUT-1: go to FAULT.
  3. CLOSE: go to DEAD, pending = CLOSE.
  4. Otherwise counter += 1.
  - OPEN while in RUN_CW is ignored.
  - Motor output is therefore high at most RUN_TIMEOUT cycles.
- RUN_CCW: symmetric to RUN_CW, using limit_closed and OPEN.
- Entry to DEAD sets counter = 0. DEAD lasts exactly DEAD_TIME cycles with both motor outputs 0.
  - A valid cmd arriving during DEAD overwrites pending (last command wins). cmd NONE leaves pending unchanged.
  - At the end of DEAD (counter == DEAD_TIME-1):
    - pending OPEN & ~limit_open: go to RUN_CW.
    - pending CLOSE & ~limit_closed: go to RUN_CCW.
    - Otherwise go to IDLE.
    - Counter = 0 and pending = NONE in every case.
- FAULT: both motor outputs 0, fault = 1. Commands and limits are ignored. Exit is via reset only.
- Counter saturation is not needed; the parameter bounds guarantee it never wraps.
- Invariant: motor_cw & motor_ccw is never 1. Any transition between RUN_CW and RUN_CCW passes through at least DEAD_TIME cycles of DEAD.

Test Plan (RUN_TIMEOUT=20, DEAD_TIME=4, CNT_W=8):
- Reset then idle: n_reset low 3 cycles, then high with no inputs -> all outputs 0, busy 0, for 10 cycles.
- Normal open: 1-cycle open_cw at edge 5, limit_open raised at edge 12 -> motor_cw high edges 6..12, DEAD edges 13..16 with busy=1, IDLE from edge 17.
- Timeout: open_cw, limits held low -> motor_cw high exactly 20 cycles, then fault=1 and motor_cw=0. Commands are then ignored until an n_reset pulse clears fault.
- Reversal: open_cw, then close_ccw 5 cycles later -> motor_cw drops; both legs low 4 cycles; motor_ccw high the next cycle. Check motor_cw & motor_ccw is never 1 over the whole run.
- Ignored commands:
  - open_cw with limit_open=1 in IDLE -> stays IDLE.
  - open_cw & close_ccw together -> no motion.
  - open_cw during RUN_CW -> counter is not restarted (timeout still at 20).
- Sensor fault / reset mid-run:
  - Both limits high during RUN_CCW -> FAULT next edge.
  - A separate run with n_reset low mid-RUN_CW -> outputs all 0 at the next edge.
